// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Parity bit and PARITY state are compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
   localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_e;

   logic parity_q, parity_d;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_STOP   = 3'd5
   } state_e;
`endif

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
   logic                 ready_q;
   logic                 busy_q;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            // ready_q is low on the first cycle out of reset, so no accept then
            if (tx_valid && ready_q) begin
               shreg_d    = tx_data;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_d   = (^tx_data) ^ ODD_BIT;
`endif
               state_d    = S_ALIGN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ALIGN: begin
            if (baud_tick) state_d = S_START;
            else           state_d = S_ALIGN;
         end
         S_START: begin
            if (baud_tick) state_d = S_DATA;
            else           state_d = S_START;
         end
         S_DATA: begin
            if (baud_tick) begin
               shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) state_d = S_STOP;
            else           state_d = S_PARITY;
         end
`endif
         S_STOP: begin
            if (baud_tick) begin
               if (stop_cnt_q == STOP_LAST) state_d = S_IDLE;
               else                         stop_cnt_d = 1'b1;
            end else begin
               state_d = S_STOP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level is decided from the state being entered so tx changes on the same edge
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_ALIGN:  tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         ready_q    <= (state_d == S_IDLE);
         busy_q     <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: tick every 4 clk, line sampled on every falling edge into a log.
module tb_uart_tx;

   localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FB   = 1 + DB + PB + 1;
   localparam int BP   = 4;
   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, tx, busy;
   logic       tx_valid1, tx_ready1, tx1, busy1;

   int errors = 0;
   int checks = 0;
   int tmode  = 1;

   logic tx_log [2][MAXC];
   logic rdy_log[2][MAXC];
   logic bsy_log[2][MAXC];

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .busy(busy)
   );

`ifdef UART_TX_PARITY_EN
   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx(tx1), .busy(busy1)
   );
`else
   assign tx1       = 1'b1;
   assign tx_ready1 = 1'b0;
   assign busy1     = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int now_idx();
      return int'($time / 10);
   endfunction

   function automatic logic get_tx(input int sel, input int i);
      if (i < 0 || i >= MAXC) return 1'bx;
      return tx_log[sel][i];
   endfunction

   function automatic logic get_rdy(input int sel, input int i);
      if (i < 0 || i >= MAXC) return 1'bx;
      return rdy_log[sel][i];
   endfunction

   function automatic logic get_bsy(input int sel, input int i);
      if (i < 0 || i >= MAXC) return 1'bx;
      return bsy_log[sel][i];
   endfunction

   // Falling-edge sampler: index n holds the values seen after the n-th rising edge
   initial begin
      forever begin
         @(negedge clk);
         if (now_idx() < MAXC) begin
            tx_log[0][now_idx()]  = tx;
            rdy_log[0][now_idx()] = tx_ready;
            bsy_log[0][now_idx()] = busy;
            tx_log[1][now_idx()]  = tx1;
            rdy_log[1][now_idx()] = tx_ready1;
            bsy_log[1][now_idx()] = busy1;
         end
      end
   end

   // Tick source: toggles every cycle in mode 1, one pulse every BP clocks in mode 0
   initial begin
      int tcnt;
      tcnt      = 0;
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tmode == 1) begin
            baud_tick = ~baud_tick;
         end else begin
            tcnt      = (tcnt + 1) % BP;
            baud_tick = (tcnt == BP - 1);
         end
      end
   end

   task automatic send(input int sel, input logic [7:0] d, input bit hold, output int acc);
      bit ok = 1'b0;
      acc = -1;
      @(negedge clk);
      tx_data = d;
      if (sel == 0) tx_valid = 1'b1;
      else          tx_valid1 = 1'b1;
      for (int n = 0; n < 400 && !ok; n++) begin
         if ((sel == 0 ? tx_ready : tx_ready1) === 1'b1) begin
            ok  = 1'b1;
            acc = now_idx() + 1;
         end else begin
            @(negedge clk);
         end
      end
      check_eq("accept", 32'(ok), 32'd1);
      @(negedge clk);
      if (!hold) begin
         tx_valid  = 1'b0;
         tx_valid1 = 1'b0;
      end
   endtask

   task automatic wait_frame();
      repeat ((FB + 2) * BP + 2) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int sel, input logic [7:0] d,
                              input int acc, output int s);
      logic [10:0] bits;
      logic [3:0]  v;
      int          e;
      s = -1;
      if (acc < 0) return;
      for (int i = acc; i <= acc + BP + 2; i++)
         if (s < 0 && get_tx(sel, i) === 1'b0) s = i;
      check_eq({tag, "_align"}, 32'((s >= acc + 1) && (s <= acc + BP)), 32'd1);
      if (s < 0) return;
      check_eq({tag, "_prestart"}, 32'(get_tx(sel, s - 1)), 32'd1);
      bits = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < DB; k++) bits[1 + k] = d[k];
      if (PB == 1) bits[1 + DB] = (^d) ^ (sel == 1);
      bits[FB - 1] = 1'b1;
      for (int k = 0; k < FB; k++) begin
         for (int j = 0; j < BP; j++) v[j] = get_tx(sel, s + k * BP + j);
         check_eq($sformatf("%s_bit%0d", tag, k), 32'(v), bits[k] ? 32'hF : 32'h0);
      end
      e = s + FB * BP;
      check_eq({tag, "_end"}, 32'({get_rdy(sel, e), get_bsy(sel, e), get_bsy(sel, e - 1)}), 32'b101);
   endtask

   initial begin
      int   a1, a2, s1, s2;
      logic all_hi, all_lo;
      logic [10:0] seq;
      rst       = 1'b1;
      tx_valid  = 1'b0;
      tx_valid1 = 1'b0;
      tx_data   = 8'h00;

      // power-on reset with tick toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("por_state", 32'({tx, busy, tx_ready}), 32'b100);
      end
      rst = 1'b0;
      @(negedge clk);
      check_eq("por_release", 32'({tx_ready, busy, tx}), 32'b101);

      // reset while idle, 3 cycles
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("idle_rst_state", 32'({tx, busy, tx_ready}), 32'b100);
      end
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_rst_release", 32'(tx_ready), 32'd1);
      tmode = 0;
      repeat (5) @(negedge clk);

      // basic 0xA5 frame
      send(0, 8'hA5, 1'b0, a1);
      wait_frame();
      check_frame("a5", 0, 8'hA5, a1, s1);
      for (int k = 0; k < FB; k++) seq[FB - 1 - k] = get_tx(0, s1 + k * BP + 1);
`ifdef UART_TX_PARITY_EN
      check_eq("a5_seq", 32'(seq), 32'b01010010101);
      check_eq("a5_par_even", 32'(get_tx(0, s1 + 9 * BP + 2)), 32'd0);
`else
      check_eq("a5_seq", 32'(seq[9:0]), 32'b0101001011);
`endif

      // back-to-back with valid held high
      send(0, 8'h00, 1'b1, a1);
      send(0, 8'hFF, 1'b0, a2);
      wait_frame();
      check_frame("b2b_00", 0, 8'h00, a1, s1);
      check_frame("b2b_ff", 0, 8'hFF, a2, s2);
      check_eq("b2b_gap", 32'(a2 - (s1 + FB * BP)), 32'd1);
      all_hi = 1'b1;
      for (int i = s1 + (FB - 1) * BP; i < s2; i++) all_hi &= get_tx(0, i);
      check_eq("b2b_line_high", 32'(all_hi), 32'd1);

      // stall: data changes mid-frame while valid stays high
      send(0, 8'h3C, 1'b1, a1);
      repeat (12) @(negedge clk);
      tx_data = 8'h55;
      send(0, 8'h55, 1'b0, a2);
      wait_frame();
      check_frame("stall_3c", 0, 8'h3C, a1, s1);
      all_lo = 1'b0;
      for (int i = a1; i < s1 + FB * BP; i++) all_lo |= get_rdy(0, i);
      check_eq("stall_ready_low", 32'(all_lo), 32'd0);
      check_eq("stall_accept", 32'(a2 - (s1 + FB * BP)), 32'd1);
      check_frame("stall_55", 0, 8'h55, a2, s2);

      // reset during data bit 3 of 0x0F
      send(0, 8'h0F, 1'b0, a1);
      s1 = -1;
      for (int n = 0; n < 2 * BP && s1 < 0; n++) begin
         if (tx === 1'b0) s1 = now_idx();
         else @(negedge clk);
      end
      check_eq("mid_start_seen", 32'(s1 >= 0), 32'd1);
      repeat (17) @(negedge clk);
      check_eq("mid_inflight", 32'({tx, busy}), 32'b11);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_state", 32'({tx, busy, tx_ready}), 32'b100);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_release", 32'({tx_ready, busy}), 32'b10);
      send(0, 8'h81, 1'b0, a1);
      wait_frame();
      check_frame("after_rst_81", 0, 8'h81, a1, s1);

`ifdef UART_TX_PARITY_EN
      send(1, 8'h07, 1'b0, a1);
      wait_frame();
      check_frame("odd_07", 1, 8'h07, a1, s1);
      check_eq("odd_07_par", 32'(get_tx(1, s1 + 9 * BP + 2)), 32'd0);
      send(0, 8'h07, 1'b0, a1);
      wait_frame();
      check_frame("even_07", 0, 8'h07, a1, s1);
      check_eq("even_07_par", 32'(get_tx(0, s1 + 9 * BP + 2)), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter.
- Sits directly downstream of the baud-rate pulse generator: its one-cycle `baud_tick` strobe sets the bit period.
- Takes bytes from the CPU/MMIO side over a valid/ready handshake.
- Shifts each byte out LSB-first on `tx` as a standard 8N1-style frame (start, data, optional parity, stop).
- Used as the TX half of the rv32i UART peripheral.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- STOP_BITS, 1, number of stop bit periods (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- baud_tick  input  1  one-cycle strobe from pulse generator, one per bit period.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has data.
- tx_ready  output  1  block can accept data; asserted only in IDLE.
- tx  output  1  serial line; idle high.
- busy  output  1  high from handshake until frame complete (any state other than IDLE).

Behaviour:
- Reset:
  - All state is clocked. `rst` high on a clock edge forces state=IDLE, tx=1, shift register=0, bit counter=0.
  - During `rst`: tx_ready=0, busy=0.
  - First cycle after `rst` deasserts: tx_ready=1.
- States: IDLE, ALIGN, START, DATA, PARITY (only with feature), STOP.
- tx is registered, driven per state:
  - IDLE=1, ALIGN=1, START=0, DATA=shreg[0], PARITY=parity bit, STOP=1.
- IDLE:
  - tx_ready=1.
  - On tx_valid & tx_ready at an edge: latch tx_data into shreg, clear counters, go to ALIGN.
  - baud_tick in IDLE is ignored.
- ALIGN:
  - tx stays 1; wait for baud_tick, then go to START.
  - This guarantees the start bit is exactly one full tick interval even though the tick generator free-runs.
  - Accept→ALIGN latency is 1 cycle; ALIGN may last 1..period cycles.
- Bit timing:
  - Every bit from START onward lasts exactly one tick interval.
  - All transitions below occur on the edge where baud_tick=1.
- START: → DATA.
- DATA:
  - On each tick: shreg shifts right by 1 and bit_cnt increments.
  - When bit_cnt==DATA_BITS-1 on a tick: → PARITY if compiled in, else → STOP.
  - bit_cnt width is $clog2(DATA_BITS); it never wraps within a frame.
- PARITY: → STOP.
- STOP:
  - Count STOP_BITS ticks. On the last one → IDLE; tx_ready rises that edge.
  - Back-to-back transfers: a valid held high is accepted on the first IDLE cycle, so there is a minimum gap of 1 clk between frames plus ALIGN.
- tx_data/tx_valid changes after acceptance do not affect the frame in flight.
- tx_valid with tx_ready=0 is neither accepted nor dropped; upstream must hold it.
- Reset mid-frame: the frame aborts; tx=1 on the next edge; no partial retransmit.
- baud_tick held high continuously is legal: each bit then lasts 1 cycle. The state machine still walks every state, so it is usable for fast simulation.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is present and adds one bit period after the data bits.
  - Parity bit = XOR of the latched data bits, XOR PARITY_ODD.
  - The parity value is captured at handshake, not recomputed from the shifting register.
- Undefined:
  - No PARITY state or logic; DATA goes directly to STOP; PARITY_ODD has no effect.

Test Plan:
- Reset check: assert rst 3 cycles mid-idle, toggle baud_tick → tx=1, busy=0, tx_ready=0 during reset; tx_ready=1 first cycle after release.
- Basic frame, no parity: pulse_generator ticks=3 (tick every 4 clk), send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1. Each bit exactly 4 clk; busy low and tx_ready high after the stop bit; total start-to-stop-end 40 clk.
- Back-to-back with valid held high: send 0x00 then 0xFF → both frames are correct; the second is accepted 1 cycle after the first stop bit ends; the line is never low between stop and ALIGN.
- Handshake stall: raise tx_valid with 0x3C while busy, change tx_data to 0x55 mid-frame → in-flight byte unchanged; 0x55 is sent next only once tx_ready=1.
- Reset mid-frame: assert rst during data bit 3 of 0x0F → tx=1 next edge, state IDLE; a new 0x81 then transmits cleanly.
- Parity (UART_TX_PARITY_EN defined):
  - PARITY_ODD=0, 0xA5 → parity bit 0.
  - PARITY_ODD=1, 0x07 → parity bit 0.
  - PARITY_ODD=0, 0x07 → parity bit 1.
  - Frame length 11 bit periods.
